// File: rtl/alu_sequencer.sv
// Single-issue ALU/memory sequencer: accepts one instruction, executes ADD/NOT
// locally or LOAD/STORE via a req/ack memory port, and holds the result until consumed.
module alu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [2:0]  instr_op,
    input  logic [15:0] instr_src,
    input  logic [15:0] instr_dst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  flags,
    output logic        err
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_NOT   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_NOP   = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_DONE} state_t;

    state_t        state;
    logic [2:0]    op_q;
    logic [DW-1:0] src_q;
    logic [DW-1:0] dst_q;
    logic [CW-1:0] wait_cnt;

    logic [DW:0]   sum;
    logic          add_ovf;
    logic [DW-1:0] not_res;

    // Datapath shared by ADD and the LOAD address
    always_comb begin
        sum     = {1'b0, src_q} + {1'b0, dst_q};
        add_ovf = (src_q[DW-1] == dst_q[DW-1]) && (sum[DW-1] != src_q[DW-1]);
        not_res = ~src_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= 3'b000;
            src_q       <= '0;
            dst_q       <= '0;
            wait_cnt    <= '0;
            instr_ready <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            flags       <= 4'b0000;
            err         <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr_op;
                        src_q       <= instr_src;
                        dst_q       <= instr_dst;
                        instr_ready <= 1'b0;
                        // err must be visible during EXEC, so it is raised on accept
                        err         <= (instr_op > OP_NOP);
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            res_data  <= sum[DW-1:0];
                            flags     <= {add_ovf, sum[DW-1], (sum[DW-1:0] == '0), sum[DW]};
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                        OP_NOT: begin
                            res_data  <= not_res;
                            flags     <= {2'b00, (not_res == '0), 1'b0};
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                        OP_LOAD: begin
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= sum[DW-1:0];
                            wait_cnt <= '0;
                            state    <= S_MEM;
                        end
                        OP_STORE: begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= src_q;
                            mem_wdata <= dst_q;
                            wait_cnt  <= '0;
                            state     <= S_MEM;
                        end
                        default: begin
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        res_data  <= mem_we ? dst_q : mem_rdata;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        instr_ready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with hand-computed expectations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op;
    logic [15:0] instr_src;
    logic [15:0] instr_dst;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  flags;
    logic        err;

    int checks   = 0;
    int failures = 0;

    alu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_src(instr_src), .instr_dst(instr_dst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .flags(flags), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in IDLE; returns in the EXEC cycle
    task automatic issue(input logic [2:0] op, input logic [15:0] src, input logic [15:0] dst);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_src   = src;
        instr_dst   = dst;
        step();
        instr_valid = 1'b0;
        instr_op    = 3'b100;
        instr_src   = 16'h0000;
        instr_dst   = 16'h0000;
    endtask

    // Consume the result in DONE and return to IDLE
    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("back_to_idle_ready", 32'(instr_ready), 32'd1);
    endtask

    initial begin
        int n_req;
        int n_err;

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = 3'b100; instr_src = '0; instr_dst = '0;
        mem_ack = 1'b0; mem_rdata = '0; res_ready = 1'b0;
        #12;
        check("rst_res_data", 32'(res_data), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_res_valid", 32'(res_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("ready_after_reset", 32'(instr_ready), 32'd1);

        // ADD 7FFF+0001: signed overflow into negative
        issue(3'b000, 16'h7FFF, 16'h0001);
        check("add1_exec_ready", 32'(instr_ready), 32'd0);
        check("add1_exec_valid", 32'(res_valid), 32'd0);
        check("add1_exec_err", 32'(err), 32'd0);
        step();
        check("add1_valid", 32'(res_valid), 32'd1);
        check("add1_data", 32'(res_data), 32'h8000);
        check("add1_flags", 32'(flags), 32'hC);
        consume();

        // Illegal opcode 110: err during EXEC, result and flags untouched
        issue(3'b110, 16'h1234, 16'h4321);
        check("ill_exec_err", 32'(err), 32'd1);
        step();
        check("ill_done_err", 32'(err), 32'd0);
        check("ill_valid", 32'(res_valid), 32'd1);
        check("ill_data", 32'(res_data), 32'h8000);
        check("ill_flags", 32'(flags), 32'hC);
        consume();

        // ADD FFFF+0001 -> zero and carry, then NOT 0000
        issue(3'b000, 16'hFFFF, 16'h0001);
        step();
        check("add2_data", 32'(res_data), 32'h0000);
        check("add2_flags", 32'(flags), 32'h3);
        consume();
        issue(3'b001, 16'h0000, 16'h9999);
        step();
        check("not_data", 32'(res_data), 32'hFFFF);
        check("not_flags", 32'(flags), 32'h0);
        consume();

        // NOP passes through DONE unchanged
        issue(3'b100, 16'hAAAA, 16'h5555);
        check("nop_exec_err", 32'(err), 32'd0);
        step();
        check("nop_valid", 32'(res_valid), 32'd1);
        check("nop_data", 32'(res_data), 32'hFFFF);
        consume();

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_ack_valid", 32'(res_valid), 32'd0);
        check("idle_ack_req", 32'(mem_req), 32'd0);
        check("idle_ack_ready", 32'(instr_ready), 32'd1);

        // LOAD 0010+0004 with ack arriving in the fourth MEM cycle
        issue(3'b010, 16'h0010, 16'h0004);
        check("ld_exec_req", 32'(mem_req), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("ld_req_held", 32'(mem_req), 32'd1);
            check("ld_addr", 32'(mem_addr), 32'h0014);
            check("ld_we", 32'(mem_we), 32'd0);
            step();
        end
        mem_ack = 1'b1; mem_rdata = 16'hABCD;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        check("ld_req_drop", 32'(mem_req), 32'd0);
        check("ld_valid", 32'(res_valid), 32'd1);
        check("ld_data", 32'(res_data), 32'hABCD);
        check("ld_flags", 32'(flags), 32'h0);
        check("ld_err", 32'(err), 32'd0);
        consume();

        // STORE 0020/5555 with no ack: timeout after 15 request cycles
        issue(3'b011, 16'h0020, 16'h5555);
        step();
        check("st_req", 32'(mem_req), 32'd1);
        check("st_addr", 32'(mem_addr), 32'h0020);
        check("st_wdata", 32'(mem_wdata), 32'h5555);
        check("st_we", 32'(mem_we), 32'd1);
        n_req = 1;
        n_err = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            step();
            if (err) n_err++;
            if (mem_req) n_req++;
        end
        check("st_req_cycles", 32'(n_req), 32'd15);
        check("st_valid", 32'(res_valid), 32'd1);
        check("st_data_kept", 32'(res_data), 32'hABCD);
        step();
        if (err) n_err++;
        check("st_err_pulses", 32'(n_err), 32'd1);
        consume();

        // DONE hold: res_ready low for 5 cycles, new instructions ignored
        issue(3'b000, 16'h0001, 16'h0002);
        step();
        instr_valid = 1'b1; instr_op = 3'b001; instr_src = 16'h00FF;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'h0003);
            check("hold_ready", 32'(instr_ready), 32'd0);
            step();
        end
        instr_valid = 1'b0;
        check("hold_flags", 32'(flags), 32'h0);
        consume();

        // Reset asserted during MEM, then a late ack
        issue(3'b010, 16'h1000, 16'h0001);
        step();
        check("rm_req_before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_req", 32'(mem_req), 32'd0);
        check("rm_addr", 32'(mem_addr), 32'h0);
        check("rm_data", 32'(res_data), 32'h0);
        check("rm_flags", 32'(flags), 32'h0);
        check("rm_valid", 32'(res_valid), 32'd0);
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        check("rm_ack_req", 32'(mem_req), 32'd0);
        check("rm_ack_valid", 32'(res_valid), 32'd0);
        check("rm_ack_data", 32'(res_data), 32'h0);
        check("rm_ack_ready", 32'(instr_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum number of cycles spent waiting for mem_ack, range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low, synchronously released.
REQ-004 instr_valid  in  1  instruction present.
REQ-005 instr_ready  out  1  sequencer can accept; high only in IDLE.
REQ-006 instr_op  in  3  000 ADD, 001 NOT, 010 LOAD, 011 STORE, 100 NOP, 101-111 illegal.
REQ-007 instr_src  in  16  source operand.
REQ-008 instr_dst  in  16  destination operand.
REQ-009 mem_req  out  1  memory request, held until ack or timeout.
REQ-010 mem_we  out  1  1 = write (STORE), 0 = read (LOAD); valid while mem_req.
REQ-011 mem_addr  out  16  memory address; valid while mem_req.
REQ-012 mem_wdata  out  16  store data; valid while mem_req and mem_we.
REQ-013 mem_ack  in  1  memory completion, single-cycle pulse.
REQ-014 mem_rdata  in  16  read data, sampled in the mem_ack cycle.
REQ-015 res_valid  out  1  result available.
REQ-016 res_ready  in  1  consumer accepts result.
REQ-017 res_data  out  16  registered result.
REQ-018 flags  out  4  registered flags: [0] carry, [1] zero, [2] negative, [3] overflow.
REQ-019 err  out  1  one-cycle pulse on illegal opcode or memory timeout.

Function
REQ-020 FSM states: IDLE, EXEC, MEM, DONE; IDLE->EXEC on instr_valid & instr_ready, capturing op, src and dst into registers.
REQ-021 EXEC lasts exactly one cycle; ADD, NOT, NOP and illegal opcodes go EXEC->DONE; LOAD and STORE go EXEC->MEM.
REQ-022 ADD: {carry,res} = src+dst (17-bit); zero = (res==0); negative = res[15]; overflow = (src[15]==dst[15]) & (res[15]!=src[15]); res_data and flags updated at the end of EXEC.
REQ-023 NOT: res = ~src; flags = {0, 0, res==0, 0} ordered as [3:0] = ovf, neg, zero, carry.
REQ-024 LOAD: mem_addr = src+dst truncated to 16 bits, mem_we=0; res_data = mem_rdata in the ack cycle; flags unchanged.
REQ-025 STORE: mem_addr = src, mem_wdata = dst, mem_we=1; res_data = dst at ack; flags unchanged.
REQ-026 NOP: res_data and flags unchanged; passes through DONE with res_valid=1.
REQ-027 Illegal opcode: treated as NOP; err pulses in the EXEC cycle.
REQ-028 mem_req rises on entry to MEM and stays high with stable addr/we/wdata until mem_ack is sampled high; an ack in the first MEM cycle is valid.
REQ-029 MEM wait counter starts at 0 on MEM entry and increments per cycle without ack; when it reaches MEM_TIMEOUT without ack: mem_req drops, err pulses, res_data unchanged, go to DONE.
REQ-030 mem_ack outside MEM is ignored.
REQ-031 DONE: res_valid=1 with res_data stable until res_ready; DONE->IDLE on res_ready; back-to-back instruction minimum period is 3 cycles for non-memory ops (accept, EXEC, DONE with res_ready=1).
REQ-032 instr_* inputs are ignored outside IDLE; captured operands remain stable for the whole operation.
REQ-033 flags change only at the end of EXEC for ADD/NOT; they hold their value in every other state and for every other opcode.

Reset
REQ-034 rst_n low forces, asynchronously, state=IDLE, res_data=0, flags=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, res_valid=0, err=0, and wait counter=0.
REQ-035 Reset during MEM drops mem_req immediately; a subsequent late mem_ack is ignored.
REQ-036 instr_ready=1 in the first cycle after rst_n release.

Verification
REQ-037 ADD src=7FFF, dst=0001 -> res_data=8000, flags=1100 (ovf=1, neg=1, zero=0, carry=0), res_valid 2 cycles after accept.
REQ-038 ADD FFFF+0001 -> res_data=0000, flags=0011 (zero, carry); then NOT 0000 -> res_data=FFFF, flags=0000.
REQ-039 LOAD src=0010, dst=0004 with ack 3 cycles late, mem_rdata=ABCD -> mem_addr=0014 with mem_we=0 held, res_data=ABCD, flags unchanged.
REQ-040 STORE src=0020, dst=5555 with ack never -> mem_req drops after MEM_TIMEOUT cycles, single err pulse, res_valid=1 with previous res_data.
REQ-041 res_ready held low 5 cycles in DONE -> res_valid and res_data stable, instr_ready=0; opcode 110 -> err pulse, flags unchanged.
REQ-042 rst_n asserted mid-MEM -> mem_req=0 immediately, all outputs at reset values; an ack then has no effect.
